// File: rtl/cgra_pkg.sv
// Shared definitions for the CGRA array: configuration register indices,
// datapath operation encoding, the ID tag and the datapath op helper.
package cgra_pkg;

    localparam logic [1:0] REG_CTRL  = 2'd0;
    localparam logic [1:0] REG_CONST = 2'd1;
    localparam logic [1:0] REG_COUNT = 2'd2;
    localparam logic [1:0] REG_ID    = 2'd3;

    localparam logic [15:0] ID_TAG = 16'hC6A0;

    typedef enum logic [1:0] {
        OP_PASS = 2'd0,
        OP_ADD  = 2'd1,
        OP_MUL  = 2'd2,
        OP_XOR  = 2'd3
    } op_e;

    // 16-bit modular datapath operation; multiply keeps the low 16 bits.
    function automatic logic [15:0] apply_op(op_e op, logic [15:0] k, logic [15:0] a);
        logic [15:0] r;
        case (op)
            OP_ADD:  r = a + k;
            OP_MUL:  r = a * k;
            OP_XOR:  r = a ^ k;
            default: r = a;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cgra_prr.sv
// One partial-reconfiguration region: CTRL/CONST/COUNT/ID register file,
// two-stage 16-bit streaming datapath and emitted-word counter.
// Ports:
//   clk, reset (async, active-low)
//   stall                      - freezes both pipeline stages, masks io1_io2g
//   cfg_wr_en/addr/data        - register write (index = addr[1:0])
//   cfg_rd_en/addr, cfg_rd_data- registered read, 0 on cycles without a read
//   io1_g2io, io16_g2io        - input word valid / data
//   io1_io2g, io16_io2g        - output word valid / data (stage 2)
module cgra_prr
    import cgra_pkg::*;
#(
    parameter int unsigned PRR_INDEX = 0,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              cfg_wr_en,
    input  logic [ADDR_W-1:0] cfg_wr_addr,
    input  logic [DATA_W-1:0] cfg_wr_data,
    input  logic              cfg_rd_en,
    input  logic [ADDR_W-1:0] cfg_rd_addr,
    output logic [DATA_W-1:0] cfg_rd_data,
    input  logic              io1_g2io,
    input  logic [15:0]       io16_g2io,
    output logic              io1_io2g,
    output logic [15:0]       io16_io2g
);

    logic        enable;
    op_e         op;
    logic [15:0] const_q;
    logic [31:0] count;
    logic        s1_valid, s2_valid;
    logic [15:0] s1_data, s2_data;
    logic [1:0]  wr_idx, rd_idx;
    logic [DATA_W-1:0] rd_mux;

    // Only the low address bits and low data bits carry meaning.
    logic unused_bits;
    assign unused_bits = ^{cfg_wr_addr[ADDR_W-1:2], cfg_rd_addr[ADDR_W-1:2],
                           cfg_wr_data[DATA_W-1:16]};

    assign wr_idx = cfg_wr_addr[1:0];
    assign rd_idx = cfg_rd_addr[1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            enable  <= 1'b0;
            op      <= OP_PASS;
            const_q <= '0;
        end else if (cfg_wr_en) begin
            case (wr_idx)
                REG_CTRL: begin
                    enable <= cfg_wr_data[0];
                    op     <= op_e'(cfg_wr_data[2:1]);
                end
                REG_CONST: const_q <= cfg_wr_data[15:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s2_valid <= 1'b0;
            s2_data  <= '0;
        end else if (!stall) begin
            s1_valid <= io1_g2io & enable;
            s1_data  <= io16_g2io;
            s2_valid <= s1_valid;
            s2_data  <= apply_op(op, const_q, s1_data);
        end
    end

    // A clear-write takes priority over a coincident increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (cfg_wr_en && wr_idx == REG_COUNT) begin
            count <= '0;
        end else if (!stall && s1_valid) begin
            count <= count + 32'd1;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (rd_idx)
            REG_CTRL:  rd_mux = DATA_W'({op, enable});
            REG_CONST: rd_mux = DATA_W'(const_q);
            REG_COUNT: rd_mux = DATA_W'(count);
            REG_ID:    rd_mux = DATA_W'({ID_TAG, 16'(PRR_INDEX)});
            default:   rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cfg_rd_data <= '0;
        end else begin
            cfg_rd_data <= cfg_rd_en ? rd_mux : '0;
        end
    end

    // Valid is masked during stall so a held word is not emitted twice.
    assign io1_io2g  = s2_valid & ~stall;
    assign io16_io2g = s2_data;

endmodule

// File: rtl/cgra_array.sv
// Behavioral CGRA array: NUM_PRR independent PRRs, each configured and
// streamed by its own GLB tile. This level only slices the flat buses.
// Ports (per PRR i, slice i of each bus):
//   clk, reset (async, active-low), stall[i]
//   cfg_wr_en/addr/data, cfg_rd_en/addr, cfg_rd_data
//   io1_g2io/io16_g2io (input stream), io1_io2g/io16_io2g (output stream)
module cgra_array
    import cgra_pkg::*;
#(
    parameter int unsigned NUM_PRR             = 16,
    parameter int unsigned CGRA_CFG_ADDR_WIDTH = 32,
    parameter int unsigned CGRA_CFG_DATA_WIDTH = 32
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [NUM_PRR-1:0]                     stall,
    input  logic [NUM_PRR-1:0]                     cfg_wr_en,
    input  logic [NUM_PRR*CGRA_CFG_ADDR_WIDTH-1:0] cfg_wr_addr,
    input  logic [NUM_PRR*CGRA_CFG_DATA_WIDTH-1:0] cfg_wr_data,
    input  logic [NUM_PRR-1:0]                     cfg_rd_en,
    input  logic [NUM_PRR*CGRA_CFG_ADDR_WIDTH-1:0] cfg_rd_addr,
    output logic [NUM_PRR*CGRA_CFG_DATA_WIDTH-1:0] cfg_rd_data,
    input  logic [NUM_PRR-1:0]                     io1_g2io,
    input  logic [NUM_PRR*16-1:0]                  io16_g2io,
    output logic [NUM_PRR-1:0]                     io1_io2g,
    output logic [NUM_PRR*16-1:0]                  io16_io2g
);

    localparam int unsigned AW = CGRA_CFG_ADDR_WIDTH;
    localparam int unsigned DW = CGRA_CFG_DATA_WIDTH;

    for (genvar i = 0; i < NUM_PRR; i++) begin : g_prr
        cgra_prr #(
            .PRR_INDEX (i),
            .ADDR_W    (AW),
            .DATA_W    (DW)
        ) u_prr (
            .clk         (clk),
            .reset       (reset),
            .stall       (stall[i]),
            .cfg_wr_en   (cfg_wr_en[i]),
            .cfg_wr_addr (cfg_wr_addr[i*AW +: AW]),
            .cfg_wr_data (cfg_wr_data[i*DW +: DW]),
            .cfg_rd_en   (cfg_rd_en[i]),
            .cfg_rd_addr (cfg_rd_addr[i*AW +: AW]),
            .cfg_rd_data (cfg_rd_data[i*DW +: DW]),
            .io1_g2io    (io1_g2io[i]),
            .io16_g2io   (io16_g2io[i*16 +: 16]),
            .io1_io2g    (io1_io2g[i]),
            .io16_io2g   (io16_io2g[i*16 +: 16])
        );
    end

endmodule

// File: tb/tb_cgra_array.sv
module tb_cgra_array;

    localparam int N = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    stall, cfg_wr_en, cfg_rd_en, io1_g2io, io1_io2g;
    logic [N*32-1:0] cfg_wr_addr, cfg_wr_data, cfg_rd_addr, cfg_rd_data;
    logic [N*16-1:0] io16_g2io, io16_io2g;

    int n_vec = 0;
    int n_bad = 0;

    // Reference state: architectural registers plus the word sequence in
    // flight (the word accepted one advance ago, and the word now shown).
    bit          m_en    [N];
    logic [1:0]  m_op    [N];
    logic [15:0] m_const [N];
    logic [31:0] m_count [N];
    bit          acc_v   [N];
    logic [15:0] acc_d   [N];
    bit          out_v   [N];
    logic [15:0] out_d   [N];
    logic [31:0] m_rd    [N];

    cgra_array #(
        .NUM_PRR             (N),
        .CGRA_CFG_ADDR_WIDTH (32),
        .CGRA_CFG_DATA_WIDTH (32)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .cfg_wr_en   (cfg_wr_en),
        .cfg_wr_addr (cfg_wr_addr),
        .cfg_wr_data (cfg_wr_data),
        .cfg_rd_en   (cfg_rd_en),
        .cfg_rd_addr (cfg_rd_addr),
        .cfg_rd_data (cfg_rd_data),
        .io1_g2io    (io1_g2io),
        .io16_g2io   (io16_g2io),
        .io1_io2g    (io1_io2g),
        .io16_io2g   (io16_io2g)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_op(input logic [1:0] op, input logic [15:0] k,
                                           input logic [15:0] a);
        int unsigned r;
        case (op)
            2'd1:    r = (int'(a) + int'(k)) % 65536;
            2'd2:    r = (int'(a) * int'(k)) % 65536;
            2'd3:    r = int'(a ^ k);
            default: r = int'(a);
        endcase
        return r[15:0];
    endfunction

    function automatic logic [31:0] ref_reg(input int p, input logic [1:0] idx);
        case (idx)
            2'd0:    return {29'd0, m_op[p], m_en[p]};
            2'd1:    return {16'd0, m_const[p]};
            2'd2:    return m_count[p];
            default: return {16'hC6A0, p[15:0]};
        endcase
    endfunction

    task automatic model_reset();
        for (int p = 0; p < N; p++) begin
            m_en[p] = 0; m_op[p] = '0; m_const[p] = '0; m_count[p] = '0;
            acc_v[p] = 0; acc_d[p] = '0; out_v[p] = 0; out_d[p] = '0; m_rd[p] = '0;
        end
    endtask

    // Applies one rising edge to the reference, using the pre-edge state.
    task automatic model_edge();
        logic [1:0] widx;
        for (int p = 0; p < N; p++) begin
            widx = cfg_wr_addr[p*32 +: 2];
            m_rd[p] = cfg_rd_en[p] ? ref_reg(p, cfg_rd_addr[p*32 +: 2]) : 32'd0;
            if (!stall[p]) begin
                if (acc_v[p]) m_count[p] = m_count[p] + 32'd1;
                out_v[p] = acc_v[p];
                out_d[p] = ref_op(m_op[p], m_const[p], acc_d[p]);
                acc_v[p] = io1_g2io[p] && m_en[p];
                acc_d[p] = io16_g2io[p*16 +: 16];
            end
            if (cfg_wr_en[p]) begin
                case (widx)
                    2'd0: begin
                        m_en[p] = cfg_wr_data[p*32];
                        m_op[p] = cfg_wr_data[p*32+1 +: 2];
                    end
                    2'd1: m_const[p] = cfg_wr_data[p*32 +: 16];
                    2'd2: m_count[p] = '0;
                    default: ;
                endcase
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (!reset) model_reset();
        else model_edge();
        #1;
        for (int p = 0; p < N; p++) begin
            check_val($sformatf("io1[%0d]", p), 32'(io1_io2g[p]), 32'(out_v[p] && !stall[p]));
            check_val($sformatf("io16[%0d]", p), 32'(io16_io2g[p*16 +: 16]), 32'(out_d[p]));
            check_val($sformatf("rd[%0d]", p), cfg_rd_data[p*32 +: 32], m_rd[p]);
        end
    endtask

    task automatic idle();
        stall = '0; cfg_wr_en = '0; cfg_rd_en = '0; io1_g2io = '0;
        cfg_wr_addr = '0; cfg_wr_data = '0; cfg_rd_addr = '0; io16_g2io = '0;
    endtask

    task automatic wr(input int p, input logic [1:0] idx, input logic [31:0] d);
        logic [31:0] a;
        a = $urandom;
        a[1:0] = idx;
        cfg_wr_en[p] = 1'b1;
        cfg_wr_addr[p*32 +: 32] = a;
        cfg_wr_data[p*32 +: 32] = d;
        step();
        cfg_wr_en[p] = 1'b0;
    endtask

    task automatic rd(input int p, input logic [1:0] idx);
        logic [31:0] a;
        a = $urandom;
        a[1:0] = idx;
        cfg_rd_en[p] = 1'b1;
        cfg_rd_addr[p*32 +: 32] = a;
        step();
        cfg_rd_en[p] = 1'b0;
    endtask

    task automatic push(input int p, input logic v, input logic [15:0] d);
        io1_g2io[p] = v;
        io16_g2io[p*16 +: 16] = d;
        step();
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, " io1"}, 32'(io1_io2g), 32'd0);
        check_val({tag, " io16"}, 32'(|io16_io2g), 32'd0);
        check_val({tag, " rd"}, 32'(|cfg_rd_data), 32'd0);
    endtask

    initial begin
        idle();
        model_reset();
        reset = 1'b0;
        #22;
        check_all_zero("reset");
        reset = 1'b1;
        step();

        rd(5, 2'd3);
        check_val("id5", cfg_rd_data[5*32 +: 32], 32'hC6A0_0005);
        rd(5, 2'd0);
        check_val("ctrl5", cfg_rd_data[5*32 +: 32], 32'd0);

        // Pass-through stream on PRR 0.
        wr(0, 2'd0, 32'd1);
        push(0, 1'b1, 16'd1);
        push(0, 1'b1, 16'd2);
        check_val("pass1", 32'(io16_io2g[15:0]), 32'd1);
        check_val("pass1v", 32'(io1_io2g[0]), 32'd1);
        push(0, 1'b1, 16'd3);
        check_val("pass2", 32'(io16_io2g[15:0]), 32'd2);
        push(0, 1'b0, 16'd0);
        check_val("pass3", 32'(io16_io2g[15:0]), 32'd3);
        step();
        rd(0, 2'd2);
        check_val("count0", cfg_rd_data[31:0], 32'd3);

        // Add with wrap, then multiply keeping low bits, on PRR 1.
        wr(1, 2'd1, 32'h0000_FFFF);
        wr(1, 2'd0, 32'd3);
        push(1, 1'b1, 16'd2);
        push(1, 1'b0, 16'd0);
        check_val("add_wrap", 32'(io16_io2g[16 +: 16]), 32'd1);
        wr(1, 2'd0, 32'd5);
        wr(1, 2'd1, 32'h0000_0100);
        push(1, 1'b1, 16'h0101);
        push(1, 1'b0, 16'd0);
        check_val("mul_low", 32'(io16_io2g[16 +: 16]), 32'h0100);

        // Stall for three cycles mid-stream on PRR 2.
        wr(2, 2'd0, 32'd1);
        for (int k = 0; k < 8; k++) begin
            stall[2] = (k >= 3 && k < 6);
            push(2, 1'b1, 16'h0200 + 16'(k));
            if (k >= 3 && k < 6) check_val("stall_noval", 32'(io1_io2g[2]), 32'd0);
        end
        stall[2] = 1'b0;
        push(2, 1'b0, 16'd0);
        step();

        // Disabled PRR 3 ignores valid input; then clear COUNT on PRR 0.
        for (int k = 0; k < 4; k++) begin
            push(3, 1'b1, 16'(k));
            check_val("dis_noval", 32'(io1_io2g[3]), 32'd0);
        end
        io1_g2io[3] = 1'b0;
        rd(3, 2'd2);
        check_val("dis_count", cfg_rd_data[3*32 +: 32], 32'd0);
        wr(0, 2'd2, 32'hFFFF_FFFF);
        rd(0, 2'd2);
        check_val("count_clr", cfg_rd_data[31:0], 32'd0);

        // Randomized traffic, with an asynchronous reset in the middle.
        for (int cyc = 0; cyc < 700; cyc++) begin
            for (int p = 0; p < N; p++) begin
                logic [31:0] a, d;
                stall[p] = ($urandom_range(7) == 0);
                io1_g2io[p] = $urandom_range(3) != 0;
                io16_g2io[p*16 +: 16] = 16'($urandom);
                cfg_wr_en[p] = ($urandom_range(11) == 0);
                cfg_rd_en[p] = $urandom_range(1) == 1;
                a = $urandom;
                d = $urandom;
                if (a[1:0] == 2'd0) d[0] = ($urandom_range(3) != 0);
                cfg_wr_addr[p*32 +: 32] = a;
                cfg_wr_data[p*32 +: 32] = d;
                cfg_rd_addr[p*32 +: 32] = $urandom;
            end
            step();
            if (cyc == 350) begin
                reset = 1'b0;
                #1;
                check_all_zero("midreset");
                model_reset();
                step();
                reset = 1'b1;
                idle();
                for (int p = 0; p < N; p++) begin
                    rd(p, 2'd0);
                    check_val($sformatf("ctrl_after_rst[%0d]", p), cfg_rd_data[p*32 +: 32], 32'd0);
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/cgra_array.md
# cgra_array

Behavioral CGRA array that the global buffer configures and streams data through in the system testbench. It holds NUM_PRR independent partial-reconfiguration regions (PRRs). Each PRR has a small configuration register file and a 16-bit, two-stage streaming datapath. The global buffer drives the configuration and g2io stream of each PRR and receives its io2g stream.

## Interface
- NUM_PRR, 16, number of PRRs (one per GLB tile).
- CGRA_CFG_ADDR_WIDTH, 32, configuration address width.
- CGRA_CFG_DATA_WIDTH, 32, configuration data width.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; all state cleared while low.
- stall  in  NUM_PRR  per-PRR pipeline freeze.
- cfg_wr_en  in  NUM_PRR  per-PRR config write strobe.
- cfg_wr_addr  in  NUM_PRR×CGRA_CFG_ADDR_WIDTH  write address.
- cfg_wr_data  in  NUM_PRR×CGRA_CFG_DATA_WIDTH  write data.
- cfg_rd_en  in  NUM_PRR  per-PRR config read strobe.
- cfg_rd_addr  in  NUM_PRR×CGRA_CFG_ADDR_WIDTH  read address.
- cfg_rd_data  out  NUM_PRR×CGRA_CFG_DATA_WIDTH  read data.
- io1_g2io  in  NUM_PRR  input word valid.
- io16_g2io  in  NUM_PRR×16  input word.
- io1_io2g  out  NUM_PRR  output word valid.
- io16_io2g  out  NUM_PRR×16  output word.

## Operation
- Register index is addr[1:0]; higher address bits are ignored. PRRs are fully independent.
- Index 0, CTRL (RW): bit0 ENABLE; bits[2:1] OP, where 0 = pass, 1 = add CONST, 2 = multiply by CONST, 3 = xor CONST. Other bits read back 0.
- Index 1, CONST (RW): bits[15:0] are the operand; upper bits read back 0.
- Index 2, COUNT (RO): count of valid words emitted on io1_io2g, 32-bit, wraps at 2^32. Any write clears it to 0.
- Index 3, ID (RO): reads {16'hC6A0, 16-bit PRR index}. Writes are ignored.
- Arithmetic is modulo 2^16. Multiply keeps the low 16 bits of the product.
- The pipeline advances only when stall[i]=0.
  - Stage 1 captures (io1_g2io & ENABLE, io16_g2io).
  - Stage 2 captures (stage-1 valid, op(stage-1 data)).
  - Stage 2 drives the io outputs.
- When stall[i]=1, both stages hold. io1_io2g[i] is forced to 0 so no word is duplicated. io16_io2g[i] holds its value. Input words presented during stall are dropped.
- ENABLE=0 blocks new words at stage 1. Words already in flight drain normally.
- OP and CONST are sampled when stage 2 captures. A config change therefore affects words that reach stage 2 on the following edge.

## Timing
- Reset values: every register, both pipeline stages, io1_io2g, io16_io2g, cfg_rd_data and COUNT are 0.
- Data latency is 2 unstalled cycles. A word accepted on edge N appears on the outputs after edge N+1 and is visible for capture at edge N+2. Throughput is one word per cycle.
- Config write takes effect on the next edge.
- Config read is registered. cfg_rd_data is valid the cycle after cfg_rd_en. On cycles without a read it returns 0.
- A write and a read to the same index on the same edge: the read returns the old value.
- COUNT increments on each edge where stage 2 is loaded with valid=1 and stall=0. If a clear-write coincides with an increment, the clear wins and COUNT becomes 0.
- Reset asserted mid-stream: all in-flight words are discarded immediately and outputs go to 0 asynchronously.

## Structure
- Package cgra_pkg holds the register index constants (CTRL=0, CONST=1, COUNT=2, ID=3), the op enum (PASS, ADD, MUL, XOR) and the ID tag 16'hC6A0.
- Sub-module cgra_prr implements one PRR: register file, pipeline and counter. It takes a PRR_INDEX parameter. cgra_array instantiates it NUM_PRR times with a generate loop and only slices the buses.

## Test plan
- Reset, then read index 3 on PRR 5 → 32'hC6A0_0005; read index 0 → 0; outputs 0.
- PRR 0: write CTRL=1 (pass), stream 1,2,3 back-to-back → io16_io2g 1,2,3 with valid, each 2 cycles after input; COUNT reads 3.
- PRR 1: CONST=16'hFFFF, CTRL=3 (add), input 2 → output 1 (wrap). Then CTRL=5 (mul), CONST=16'h0100, input 16'h0101 → 16'h0100.
- PRR 2 streaming with stall high for 3 cycles mid-stream → no valid output during stall, no duplicates or losses for words accepted before the stall, and words offered during the stall are dropped.
- ENABLE=0 with io1_g2io high → no valid output, COUNT unchanged. Write COUNT → reads 0.
- Assert reset during a stream on all PRRs → outputs 0 at once; after release, CTRL reads 0.
